// File: rtl/tnn_pkg.sv
// Shared types and helpers for the temporal spiking column. The constants here
// describe the reference build; tnn_column derives its own widths from its parameters.
package tnn_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_LEARN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int T_PERIOD_REF   = 8;
  localparam int WBITS_REF      = 3;
  localparam int NUM_INPUTS_REF = 8;

  localparam int TW    = $clog2(T_PERIOD_REF);
  localparam int WMAX  = 2**WBITS_REF - 1;
  localparam int PBITS = WBITS_REF + $clog2(NUM_INPUTS_REF) + TW + 1;

  typedef struct packed {
    logic          no_spike;
    logic [TW-1:0] spk_time;
  } spike_t;

  // Saturating +1 / -1 step on a weight held in [0, wmax].
  function automatic int sat_inc_dec(input int w, input logic inc, input int wmax);
    if (inc) return (w >= wmax) ? wmax : w + 1;
    else     return (w <= 0)    ? 0    : w - 1;
  endfunction

endpackage

// File: rtl/tnn_column_if.sv
// Volley input and result output handshakes of the column.
interface tnn_column_if #(
  parameter int NUM_INPUTS  = 8,
  parameter int NUM_NEURONS = 4,
  parameter int T_PERIOD    = 8
);
  localparam int TW = $clog2(T_PERIOD);

  logic                           in_valid;
  logic                           in_ready;
  logic [NUM_INPUTS*(TW+1)-1:0]   in_times;
  logic                           learn_en;
  logic                           out_valid;
  logic                           out_ready;
  logic                           out_fired;
  logic [$clog2(NUM_NEURONS)-1:0] out_winner;
  logic [TW-1:0]                  out_time;

  modport master (
    output in_valid, in_times, learn_en, out_ready,
    input  in_ready, out_valid, out_fired, out_winner, out_time
  );

  modport slave (
    input  in_valid, in_times, learn_en, out_ready,
    output in_ready, out_valid, out_fired, out_winner, out_time
  );
endinterface

// File: rtl/tnn_neuron.sv
// One non-leaky ramp-response neuron: accumulates active weights each step and
// raises fire_now_o on the single step where its potential first reaches threshold.
module tnn_neuron #(
  parameter int NUM_INPUTS = 8,
  parameter int WBITS      = 3,
  parameter int PBITS      = 10,
  parameter int THRESHOLD  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear_i,
  input  logic                        step_i,
  input  logic [NUM_INPUTS-1:0]       active_i,
  input  logic [NUM_INPUTS*WBITS-1:0] weights_i,
  output logic                        fire_now_o
);

  logic [PBITS-1:0] pot_q, pot_d, sum;
  logic             fired_q, fired_d;

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (active_i[i]) sum = sum + PBITS'(weights_i[i*WBITS +: WBITS]);
    end

    pot_d      = pot_q;
    fired_d    = fired_q;
    fire_now_o = 1'b0;
    if (clear_i) begin
      pot_d   = '0;
      fired_d = 1'b0;
    end else if (step_i) begin
      pot_d      = pot_q + sum;
      fire_now_o = !fired_q && (int'(pot_d) >= THRESHOLD);
      fired_d    = fired_q | fire_now_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pot_q   <= '0;
      fired_q <= 1'b0;
    end else begin
      pot_q   <= pot_d;
      fired_q <= fired_d;
    end
  end

endmodule

// File: rtl/tnn_column.sv
// Temporal spiking column: one volley per gamma cycle, 1-WTA (earliest, then lowest
// index), optional saturating STDP, result held until consumed.
module tnn_column
  import tnn_pkg::*;
#(
  parameter int NUM_INPUTS  = 8,
  parameter int NUM_NEURONS = 4,
  parameter int T_PERIOD    = 8,
  parameter int WBITS       = 3,
  parameter int THRESHOLD   = 8,
  parameter int WINIT       = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  tnn_column_if.slave                    bus,
  input  logic                           wr_en,
  input  logic [$clog2(NUM_NEURONS)-1:0] wr_neuron,
  input  logic [$clog2(NUM_INPUTS)-1:0]  wr_input,
  input  logic [WBITS-1:0]               wr_data,
  input  logic [$clog2(NUM_NEURONS)-1:0] rd_neuron,
  input  logic [$clog2(NUM_INPUTS)-1:0]  rd_input,
  output logic [WBITS-1:0]               rd_data
);

  localparam int C_TW    = $clog2(T_PERIOD);
  localparam int C_WMAX  = 2**WBITS - 1;
  localparam int C_PBITS = WBITS + $clog2(NUM_INPUTS) + C_TW + 1;
  localparam int SW      = C_TW + 1;
  localparam int NW      = $clog2(NUM_NEURONS);
  localparam logic [C_TW-1:0] T_LAST = C_TW'(T_PERIOD - 1);

  state_e                    state_q, state_d;
  logic [C_TW-1:0]           t_q, t_d;
  logic [NUM_INPUTS*SW-1:0]  times_q, times_d;
  logic                      learn_q, learn_d;
  logic                      win_set_q, win_set_d;
  logic [NW-1:0]             win_q, win_d;
  logic [C_TW-1:0]           win_t_q, win_t_d;
  logic [WBITS-1:0]          w_q [NUM_NEURONS][NUM_INPUTS];
  logic [WBITS-1:0]          w_d [NUM_NEURONS][NUM_INPUTS];

  logic                      accept, step;
  logic [NUM_INPUTS-1:0]     active, spk_by_win;
  logic [NUM_NEURONS-1:0]    fire_now;
  logic [NUM_INPUTS*WBITS-1:0] row [NUM_NEURONS];
  logic                      fire_any;
  logic [NW-1:0]             fire_idx;

  // Out-of-range times can never satisfy the compare because tref stays below T_PERIOD.
  function automatic logic spiked_by(input logic [SW-1:0] s, input logic [C_TW-1:0] tref);
    return !s[SW-1] && (s[C_TW-1:0] <= tref);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      active[i]     = spiked_by(times_q[i*SW +: SW], t_q);
      spk_by_win[i] = spiked_by(times_q[i*SW +: SW], win_t_q);
    end
    for (int j = 0; j < NUM_NEURONS; j++) begin
      row[j] = '0;
      for (int i = 0; i < NUM_INPUTS; i++) row[j][i*WBITS +: WBITS] = w_q[j][i];
    end
  end

  for (genvar j = 0; j < NUM_NEURONS; j++) begin : g_neuron
    tnn_neuron #(
      .NUM_INPUTS (NUM_INPUTS),
      .WBITS      (WBITS),
      .PBITS      (C_PBITS),
      .THRESHOLD  (THRESHOLD)
    ) u_neuron (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (accept),
      .step_i     (step),
      .active_i   (active),
      .weights_i  (row[j]),
      .fire_now_o (fire_now[j])
    );
  end

  always_comb begin
    fire_any = |fire_now;
    fire_idx = '0;
    for (int j = NUM_NEURONS - 1; j >= 0; j--) begin
      if (fire_now[j]) fire_idx = NW'(j);
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (t_q == T_LAST) state_d = S_LEARN;
      end
      S_LEARN: state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    t_d       = t_q;
    times_d   = times_q;
    learn_d   = learn_q;
    win_set_d = win_set_q;
    win_d     = win_q;
    win_t_d   = win_t_q;
    w_d       = w_q;

    if (accept) begin
      t_d       = '0;
      times_d   = bus.in_times;
      learn_d   = bus.learn_en;
      win_set_d = 1'b0;
      win_d     = '0;
      win_t_d   = '0;
    end

    if (step) begin
      if (t_q != T_LAST) t_d = t_q + 1'b1;
      if (!win_set_q && fire_any) begin
        win_set_d = 1'b1;
        win_d     = fire_idx;
        win_t_d   = t_q;
      end
    end

    if (state_q == S_IDLE && wr_en) w_d[wr_neuron][wr_input] = wr_data;

    // In LEARN t_q rests at T_LAST, so 'active' is exactly "spiked this volley".
    if (state_q == S_LEARN && learn_q) begin
      for (int j = 0; j < NUM_NEURONS; j++) begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
          if (win_set_q) begin
            if (win_q == NW'(j))
              w_d[j][i] = WBITS'(sat_inc_dec(int'(w_q[j][i]), spk_by_win[i], C_WMAX));
          end else if (active[i]) begin
            w_d[j][i] = WBITS'(sat_inc_dec(int'(w_q[j][i]), 1'b1, C_WMAX));
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      t_q       <= '0;
      times_q   <= '0;
      learn_q   <= 1'b0;
      win_set_q <= 1'b0;
      win_q     <= '0;
      win_t_q   <= '0;
      for (int j = 0; j < NUM_NEURONS; j++)
        for (int i = 0; i < NUM_INPUTS; i++)
          w_q[j][i] <= WBITS'(WINIT);
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      times_q   <= times_d;
      learn_q   <= learn_d;
      win_set_q <= win_set_d;
      win_q     <= win_d;
      win_t_q   <= win_t_d;
      w_q       <= w_d;
    end
  end

  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.out_valid  = (state_q == S_DONE);
  assign bus.out_fired  = win_set_q;
  assign bus.out_winner = win_q;
  assign bus.out_time   = win_t_q;
  assign rd_data        = w_q[rd_neuron][rd_input];

endmodule

// File: tb/tb_tnn_column.sv
// Bench for tnn_column with 4 inputs, 2 neurons, T_PERIOD 8, 3-bit weights, threshold 8.
module tb_tnn_column;
  import tnn_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic       wr_neuron;
  logic [1:0] wr_input;
  logic [2:0] wr_data;
  logic       rd_neuron;
  logic [1:0] rd_input;
  logic [2:0] rd_data;

  tnn_column_if #(.NUM_INPUTS(4), .NUM_NEURONS(2), .T_PERIOD(8)) bus ();

  tnn_column #(
    .NUM_INPUTS(4), .NUM_NEURONS(2), .T_PERIOD(8),
    .WBITS(3), .THRESHOLD(8), .WINIT(0)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .wr_en(wr_en), .wr_neuron(wr_neuron), .wr_input(wr_input), .wr_data(wr_data),
    .rd_neuron(rd_neuron), .rd_input(rd_input), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fired;
    logic       win;
    logic [2:0] tm;
  } res_t;

  typedef struct {
    logic [11:0] w0;
    logic [11:0] w1;
    logic [15:0] times;
    logic        learn;
    res_t        exp_res;
    logic [11:0] exp_w0;
    logic [11:0] exp_w1;
  } vec_t;

  localparam logic [3:0] NS = 4'b1000;

  int   n_cmp  = 0;
  int   n_fail = 0;
  res_t sb[$];
  vec_t vt[10];

  function automatic logic [11:0] wv(input int a, input int b, input int c, input int d);
    return {d[2:0], c[2:0], b[2:0], a[2:0]};
  endfunction

  function automatic logic [3:0] sp(input int t);
    spike_t s;
    s.no_spike = 1'b0;
    s.spk_time = t[2:0];
    return s;
  endfunction

  function automatic logic [15:0] tv(input logic [3:0] a, input logic [3:0] b,
                                     input logic [3:0] c, input logic [3:0] d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_w(input logic [11:0] a, input logic [11:0] b);
    logic [11:0] r;
    for (int j = 0; j < 2; j++) begin
      r = (j == 0) ? a : b;
      for (int i = 0; i < 4; i++) begin
        wr_en     = 1'b1;
        wr_neuron = j[0];
        wr_input  = i[1:0];
        wr_data   = r[i*3 +: 3];
        tick();
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic check_w(input string tag, input logic [11:0] a, input logic [11:0] b);
    logic [11:0] r;
    for (int j = 0; j < 2; j++) begin
      r = (j == 0) ? a : b;
      for (int i = 0; i < 4; i++) begin
        rd_neuron = j[0];
        rd_input  = i[1:0];
        #1;
        chk($sformatf("%s w%0d_%0d", tag, j, i), int'(rd_data), int'(r[i*3 +: 3]));
      end
    end
  endtask

  // Offer a volley, push its expected result, wait for out_valid and score it.
  task automatic send(input string tag, input logic [15:0] times, input logic le,
                      input res_t e);
    res_t got_e;
    int   lat;
    chk({tag, " in_ready"}, int'(bus.in_ready), 1);
    sb.push_back(e);
    bus.in_times = times;
    bus.learn_en = le;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.learn_en = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, lat, 9);
    if (sb.size() == 0) begin
      chk({tag, " scoreboard"}, 0, 1);
    end else begin
      got_e = sb.pop_front();
      chk({tag, " fired"},  int'(bus.out_fired),  int'(got_e.fired));
      chk({tag, " winner"}, int'(bus.out_winner), int'(got_e.win));
      chk({tag, " time"},   int'(bus.out_time),   int'(got_e.tm));
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_times = '0; bus.learn_en = 1'b0; bus.out_ready = 1'b0;
    wr_en = 1'b0; wr_neuron = 1'b0; wr_input = '0; wr_data = '0;
    rd_neuron = 1'b0; rd_input = '0;

    vt[0] = '{w0: wv(2,2,2,2), w1: wv(1,1,1,1), times: tv(sp(0),sp(0),sp(1),NS), learn: 1'b0,
              exp_res: '{fired: 1'b1, win: 1'b0, tm: 3'd1}, exp_w0: wv(2,2,2,2), exp_w1: wv(1,1,1,1)};
    vt[1] = '{w0: wv(2,2,2,2), w1: wv(1,1,1,1), times: tv(sp(0),sp(0),sp(1),NS), learn: 1'b1,
              exp_res: '{fired: 1'b1, win: 1'b0, tm: 3'd1}, exp_w0: wv(3,3,3,1), exp_w1: wv(1,1,1,1)};
    vt[2] = '{w0: wv(7,2,2,2), w1: wv(1,1,1,1), times: tv(sp(0),sp(0),sp(1),NS), learn: 1'b1,
              exp_res: '{fired: 1'b1, win: 1'b0, tm: 3'd0}, exp_w0: wv(7,3,1,1), exp_w1: wv(1,1,1,1)};
    vt[3] = '{w0: wv(0,0,0,0), w1: wv(0,0,0,0), times: tv(sp(0),sp(0),sp(0),NS), learn: 1'b1,
              exp_res: '{fired: 1'b0, win: 1'b0, tm: 3'd0}, exp_w0: wv(1,1,1,0), exp_w1: wv(1,1,1,0)};
    vt[4] = '{w0: wv(2,2,2,2), w1: wv(2,2,2,2), times: tv(sp(0),sp(0),sp(0),sp(0)), learn: 1'b0,
              exp_res: '{fired: 1'b1, win: 1'b0, tm: 3'd0}, exp_w0: wv(2,2,2,2), exp_w1: wv(2,2,2,2)};
    vt[5] = '{w0: wv(2,2,2,2), w1: wv(2,2,2,2), times: tv(sp(0),sp(0),sp(1),sp(1)), learn: 1'b0,
              exp_res: '{fired: 1'b1, win: 1'b0, tm: 3'd1}, exp_w0: wv(2,2,2,2), exp_w1: wv(2,2,2,2)};
    vt[6] = '{w0: wv(1,1,1,1), w1: wv(3,3,3,3), times: tv(sp(2),sp(2),NS,NS), learn: 1'b1,
              exp_res: '{fired: 1'b1, win: 1'b1, tm: 3'd3}, exp_w0: wv(1,1,1,1), exp_w1: wv(4,4,2,2)};
    vt[7] = '{w0: wv(3,3,0,0), w1: wv(0,0,0,0), times: tv(sp(0),sp(1),NS,NS), learn: 1'b1,
              exp_res: '{fired: 1'b1, win: 1'b0, tm: 3'd1}, exp_w0: wv(4,4,0,0), exp_w1: wv(0,0,0,0)};
    vt[8] = '{w0: wv(1,1,1,1), w1: wv(0,0,0,0), times: tv(sp(0),sp(7),NS,NS), learn: 1'b1,
              exp_res: '{fired: 1'b1, win: 1'b0, tm: 3'd7}, exp_w0: wv(2,2,0,0), exp_w1: wv(0,0,0,0)};
    vt[9] = '{w0: wv(0,0,0,0), w1: wv(1,1,1,1), times: tv(NS,NS,NS,NS), learn: 1'b1,
              exp_res: '{fired: 1'b0, win: 1'b0, tm: 3'd0}, exp_w0: wv(0,0,0,0), exp_w1: wv(1,1,1,1)};

    tick();
    tick();
    chk("rst in_ready",  int'(bus.in_ready),  1);
    chk("rst out_valid", int'(bus.out_valid), 0);
    chk("rst out_fired", int'(bus.out_fired), 0);
    chk("rst out_time",  int'(bus.out_time),  0);
    check_w("rst", wv(0,0,0,0), wv(0,0,0,0));
    rst = 1'b0;
    tick();

    for (int k = 0; k < 10; k++) begin
      load_w(vt[k].w0, vt[k].w1);
      send($sformatf("vec%0d", k), vt[k].times, vt[k].learn, vt[k].exp_res);
      consume();
      chk($sformatf("vec%0d idle", k), int'(bus.in_ready), 1);
      check_w($sformatf("vec%0d", k), vt[k].exp_w0, vt[k].exp_w1);
    end

    // Backpressure: result held, input blocked, weight writes dropped outside IDLE.
    load_w(wv(2,2,2,2), wv(1,1,1,1));
    send("bp", tv(sp(0),sp(0),sp(1),NS), 1'b0, '{fired: 1'b1, win: 1'b0, tm: 3'd1});
    for (int k = 0; k < 5; k++) begin
      chk("bp out_valid", int'(bus.out_valid),  1);
      chk("bp in_ready",  int'(bus.in_ready),   0);
      chk("bp fired",     int'(bus.out_fired),  1);
      chk("bp winner",    int'(bus.out_winner), 0);
      chk("bp time",      int'(bus.out_time),   1);
      wr_en     = (k == 1);
      wr_neuron = 1'b0;
      wr_input  = 2'd0;
      wr_data   = 3'd5;
      tick();
      wr_en = 1'b0;
    end
    rd_neuron = 1'b0;
    rd_input  = 2'd0;
    #1;
    chk("bp gated write", int'(rd_data), 2);
    consume();
    chk("bp released out_valid", int'(bus.out_valid), 0);
    chk("bp released in_ready",  int'(bus.in_ready),  1);

    // Reset in the middle of RUN aborts the volley and restores WINIT weights.
    load_w(wv(5,2,2,2), wv(1,1,1,1));
    bus.in_times = tv(sp(0),sp(0),sp(0),sp(0));
    bus.learn_en = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("midrun in_ready", int'(bus.in_ready), 0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk("midrun rst in_ready",  int'(bus.in_ready),  1);
    chk("midrun rst out_valid", int'(bus.out_valid), 0);
    chk("midrun rst out_fired", int'(bus.out_fired), 0);
    check_w("midrun rst", wv(0,0,0,0), wv(0,0,0,0));
    rst = 1'b0;
    tick();
    repeat (12) tick();
    chk("post rst out_valid", int'(bus.out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
